// File: rtl/real_pkg.sv
// -----------------------------------------------------------------------------
// real_pkg
// Shared definitions for the real_adder_pipe slice: IEEE-754 double field
// positions, a 64-bit real word type and a NaN classifier.
// No ports (package).
// -----------------------------------------------------------------------------
package real_pkg;

  localparam int DATA_W   = 64;
  localparam int SIGN_BIT = 63;
  localparam int EXP_MSB  = 62;
  localparam int EXP_LSB  = 52;
  localparam int MAN_MSB  = 51;

  typedef logic [DATA_W-1:0] real_word_t;

  // NaN: exponent all ones and a nonzero mantissa (infinity has a zero mantissa).
  function automatic logic is_nan(input real_word_t w);
    return (&w[EXP_MSB:EXP_LSB]) && (|w[MAN_MSB:0]);
  endfunction

endpackage

// File: rtl/real_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// real_adder_pipe_if
// Valid/ready handshake bundle for real_adder_pipe.
//   io_in_valid / io_in_ready  : input transaction handshake
//   io_in_op                   : 0 = a1+a2, 1 = a1-a2 (all lanes)
//   io_in_a1 / io_in_a2        : packed operands, lane i at [i*DATA_W +: DATA_W]
//   io_out_valid / io_out_ready: result handshake
//   io_out_c                   : packed results
// Modports: master = producer/consumer side, slave = the adder pipeline.
// -----------------------------------------------------------------------------
interface real_adder_pipe_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64
);

  logic                    io_in_valid;
  logic                    io_in_ready;
  logic                    io_in_op;
  logic [LANES*DATA_W-1:0] io_in_a1;
  logic [LANES*DATA_W-1:0] io_in_a2;
  logic                    io_out_valid;
  logic                    io_out_ready;
  logic [LANES*DATA_W-1:0] io_out_c;

  modport master (
    output io_in_valid, io_in_op, io_in_a1, io_in_a2, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_c
  );

  modport slave (
    input  io_in_valid, io_in_op, io_in_a1, io_in_a2, io_out_ready,
    output io_in_ready, io_out_valid, io_out_c
  );

endinterface

// File: rtl/BBFAdd.sv
// -----------------------------------------------------------------------------
// BBFAdd
// Combinational IEEE-754 double-precision adder black box. This body is the
// behavioural stand-in used for simulation; the implementation flow binds the
// vendor floating-point adder of the same name and port list in its place.
//   in1, in2 : 64-bit double operands
//   out      : in1 + in2, round to nearest even
// -----------------------------------------------------------------------------
module BBFAdd (
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  output logic [63:0] out
);

  assign out = $realtobits($bitstoreal(in1) + $bitstoreal(in2));

endmodule

// File: rtl/real_adder_lane.sv
// -----------------------------------------------------------------------------
// real_adder_lane
// One adder lane: optional sign flip of the second operand, then BBFAdd.
//   a1_i : first operand (passed through untouched)
//   a2_i : second operand
//   op_i : 0 = add, 1 = subtract (inverts the sign bit of a2_i)
//   c_o  : combinational result
// -----------------------------------------------------------------------------
module real_adder_lane
  import real_pkg::*;
(
  input  real_word_t a1_i,
  input  real_word_t a2_i,
  input  logic       op_i,
  output real_word_t c_o
);

  real_word_t a2_eff;

  // a - b == a + (-b) exactly in IEEE-754, so subtraction is just a sign flip.
  assign a2_eff = {a2_i[SIGN_BIT] ^ op_i, a2_i[SIGN_BIT-1:0]};

  BBFAdd u_bbf_add (
    .in1 (a1_i),
    .in2 (a2_eff),
    .out (c_o)
  );

endmodule

// File: rtl/real_adder_pipe.sv
// -----------------------------------------------------------------------------
// real_adder_pipe
// LANES parallel double-precision adders followed by a STAGES-deep register
// pipeline with valid/ready flow control, lane-wide stall and bubble collapse.
//   clock         : sole clock, rising edge
//   reset         : synchronous, active-high
//   io            : real_adder_pipe_if.slave (input and output handshakes)
//   io_count      : number of consumed results, wraps at 2^CNT_W
//   io_nan_sticky : set when a consumed result holds a NaN in any lane;
//                   present only when REAL_ADDER_NAN_FLAG_EN is defined
// Latency with no backpressure is STAGES cycles; throughput one per cycle.
// -----------------------------------------------------------------------------
module real_adder_pipe
  import real_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  real_adder_pipe_if.slave io,
  output logic [CNT_W-1:0] io_count
`ifdef REAL_ADDER_NAN_FLAG_EN
  ,
  output logic             io_nan_sticky
`endif
);

  if (DATA_W != real_pkg::DATA_W) begin : g_bad_data_w
    $error("real_adder_pipe: DATA_W must be 64 to match BBFAdd");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("real_adder_pipe: LANES must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("real_adder_pipe: STAGES must be >= 1");
  end

  localparam int VEC_W = LANES * DATA_W;

  // ---------------------------------------------------------------------------
  // Adder lanes
  // ---------------------------------------------------------------------------
  logic [VEC_W-1:0] sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    real_adder_lane u_lane (
      .a1_i (io.io_in_a1[i*DATA_W +: DATA_W]),
      .a2_i (io.io_in_a2[i*DATA_W +: DATA_W]),
      .op_i (io.io_in_op),
      .c_o  (sum[i*DATA_W +: DATA_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][VEC_W-1:0] data_q, data_d;
  logic [STAGES-1:0]            move;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         out_fire;

  // A stage may move when it is empty or its successor moves; the chain runs
  // from the output backwards, which is what lets bubbles collapse under stall.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    move           = '0;
    move[STAGES-1] = !valid_q[STAGES-1] || io.io_out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      move[k] = !valid_q[k+1] || move[k+1];
    end
  end

  // Data only loads with a valid incoming entry so idle cycles do not toggle
  // the wide registers and io_out_c stays put while io_out_valid is low.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (move[0]) begin
      valid_d[0] = io.io_in_valid;
      if (io.io_in_valid) data_d[0] = sum;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (move[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  assign out_fire = valid_q[STAGES-1] && io.io_out_ready;
  assign count_d  = count_q + CNT_W'(out_fire);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the wide data registers are reset as well, so io_out_c reads zero
  // after reset instead of stale results from dropped transactions.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign io.io_in_ready  = move[0];
  assign io.io_out_valid = valid_q[STAGES-1];
  assign io.io_out_c     = data_q[STAGES-1];
  assign io_count        = count_q;

  // ---------------------------------------------------------------------------
  // Optional sticky NaN flag
  // ---------------------------------------------------------------------------
`ifdef REAL_ADDER_NAN_FLAG_EN
  logic out_nan;
  logic nan_q, nan_d;

  always_comb begin
    out_nan = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      out_nan = out_nan | is_nan(data_q[STAGES-1][i*DATA_W +: DATA_W]);
    end
  end

  assign nan_d = nan_q | (out_fire && out_nan);

  always_ff @(posedge clock) begin
    if (reset) nan_q <= 1'b0;
    else       nan_q <= nan_d;
  end

  assign io_nan_sticky = nan_q;
`endif

endmodule

// File: doc/real_adder_pipe.md
Name: real_adder_pipe

Overview:
- Multi-lane, pipelined successor to the single-register real adder.
- Each lane feeds a pair of 64-bit IEEE-754 doubles into a combinational BBFAdd black box, with a per-transaction add/subtract select.
- The result passes through a parametrised register pipeline with valid/ready flow control, lane-wide stall and bubble collapse.
- Sits between vector producers (e.g. DSP datapaths) and consumers that may apply backpressure.

Parameters:
- LANES, 2, number of parallel adder lanes (>=1).
- STAGES, 2, pipeline register stages after the adder (>=1); this is the latency with no backpressure.
- DATA_W, 64, operand width; fixed at 64 to match BBFAdd, and elaboration errors otherwise.
- CNT_W, 32, width of the completed-transaction counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  input transaction valid.
- io_in_ready  output  1  block can accept an input this cycle.
- io_in_op  input  1  0 = a1+a2, 1 = a1-a2 (applies to all lanes).
- io_in_a1  input  LANES*DATA_W  packed first operands; lane i occupies bits [i*64 +: 64].
- io_in_a2  input  LANES*DATA_W  packed second operands.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts the result.
- io_out_c  output  LANES*DATA_W  packed results.
- io_count  output  CNT_W  number of results consumed (out_valid && out_ready).

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset clears all stage valid bits, all stage data registers, io_count and the optional flag to 0. After reset: io_out_valid=0, io_out_c=0, io_in_ready=1.
- Reset asserted mid-operation drops every in-flight transaction; nothing is emitted for them.
- Subtract: lane operand a2 has bit 63 inverted before BBFAdd; a1 is untouched. No other arithmetic is done in RTL.
- Pipeline: stage k (0..STAGES-1) holds valid_k and data_k (LANES*64). Stage 0 captures the BBFAdd outputs on input handshake. The last stage drives io_out_valid/io_out_c.
- Advance rule:
  - The last stage moves when !valid_last || io_out_ready.
  - Stage k moves when !valid_{k+1} || stage k+1 moves.
  - io_in_ready = stage-0 move condition.
  - A stage that moves loads its predecessor (stage 0 loads the input) and takes valid = predecessor valid (stage 0 takes valid = io_in_valid).
  - Bubbles collapse under stall, so all STAGES entries can fill.
- Data registers load only when the incoming valid is 1; otherwise they hold. This keeps idle toggling down, and io_out_c stays stable while io_out_valid=0.
- Latency: an input accepted at cycle t appears with io_out_valid=1 at cycle t+STAGES, given no backpressure.
- Throughput: 1 transaction/cycle when io_out_ready is held at 1. Order is preserved.
- Output hold: while io_out_valid=1 && !io_out_ready, io_out_c is held stable.
- Full pipeline: when every stage is valid and io_out_ready=0, io_in_ready=0.
- Simultaneous output and input handshake in the same cycle is legal, with no bubble inserted.
- io_count increments by 1 on each output handshake and wraps at 2^CNT_W-1 → 0.

Optional Feature:
- REAL_ADDER_NAN_FLAG_EN defined:
  - Adds output io_nan_sticky (1 bit).
  - It is set when an output handshake occurs and any lane's result has exponent bits [62:52] all ones and a nonzero mantissa [51:0].
  - It is cleared only by reset.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package real_pkg holds:
  - DATA_W = 64, SIGN_BIT = 63, EXP_MSB = 62, EXP_LSB = 52, MAN_MSB = 51;
  - a typedef for a 64-bit real word;
  - an is_nan function.
- Sub-module real_adder_lane: sign-flip mux plus BBFAdd instance, one per lane, generated LANES times.
- Pipeline registers stay in the top module.

Test Plan:
- Basic add, LANES=2, STAGES=2: a1={1.0=0x3FF0000000000000, 2.0=0x4000000000000000}, a2={2.0, 1.0}, op=0 → 2 cycles later out_c={3.0=0x4008000000000000, 3.0}, out_valid for exactly 1 cycle with ready=1.
- Subtract: a1=3.0, a2=1.0, op=1 → out_c=2.0 (0x4000000000000000) in every lane; a1=1.0, a2=1.0, op=1 → 0x0000000000000000.
- Backpressure:
  - Stream 5 transactions, io_out_ready=0 from cycle 3: in_ready drops after STAGES entries are held and out_c stays stable.
  - Release ready: all 5 results emerge in order, io_count=5.
- Back-to-back: 100 transactions with in_valid=1 and out_ready=1 throughout → one result per cycle, no gaps, io_count=100.
- Reset mid-stream: assert reset with 2 transactions in flight → next cycle out_valid=0, out_c=0, io_count=0, in_ready=1; the dropped results never appear.
- NaN flag (macro on): a1=0x7FF8000000000000 in lane 1 → io_nan_sticky=1 after the output handshake, and it stays 1 through later normal results until reset.
